// File: rtl/mod_m_counter_bank.sv
// mod_m_counter_bank: C independent modulo counters / tick generators.
// Each channel has a runtime modulus staged in a shadow register that
// takes effect only at a wrap or a clear, plus periodic/one-shot mode.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   en[C]       per-channel count enable
//   clr[C]      per-channel synchronous clear
//   cfg_we      config write strobe
//   cfg_ch      target channel (values >= C are ignored)
//   cfg_limit   new limit (modulus-1)
//   cfg_oneshot new mode, 1 = one-shot
//   q[C*N]      counter values, channel i on q[i*N +: N]
//   tick[C]     terminal-count pulse
//   done[C]     one-shot completed
module mod_m_counter_bank #(
   parameter int N         = 4,
   parameter int C         = 2,
   parameter int M_DEFAULT = 10,
   localparam int CW       = (C > 1) ? $clog2(C) : 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [C-1:0]   en,
   input  logic [C-1:0]   clr,
   input  logic           cfg_we,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [N-1:0]   cfg_limit,
   input  logic           cfg_oneshot,
   output logic [C*N-1:0] q,
   output logic [C-1:0]   tick,
   output logic [C-1:0]   done
);

   localparam logic [N-1:0] LIM_RST = N'(M_DEFAULT - 1);

   for (genvar i = 0; i < C; i++) begin : g_ch
      logic [N-1:0] cnt;
      logic [N-1:0] limit;
      logic [N-1:0] sh_limit;
      logic         os;
      logic         sh_os;
      logic         pend;
      logic         dn;
      logic         at_lim;
      logic         wrap;
      logic         apply;
      logic         wr;

      assign at_lim = (cnt == limit);
      assign wrap   = en[i] & ~dn & ~clr[i] & at_lim;
      // Staged config may only land where a new period begins.
      assign apply  = clr[i] | wrap;
      // Only in-range channel numbers can match a generated index.
      assign wr     = cfg_we & (cfg_ch == CW'(i));

      assign tick[i]        = wrap;
      assign done[i]        = dn;
      assign q[i*N +: N]    = cnt;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt      <= '0;
            limit    <= LIM_RST;
            os       <= 1'b0;
            sh_limit <= LIM_RST;
            sh_os    <= 1'b0;
            pend     <= 1'b0;
            dn       <= 1'b0;
         end else begin
            if (clr[i]) begin
               cnt <= '0;
               dn  <= 1'b0;
            end else if (en[i] && !dn) begin
               if (at_lim) begin
                  cnt <= '0;
                  // Mode in force before the wrap decides completion.
                  if (os)
                     dn <= 1'b1;
               end else begin
                  cnt <= cnt + N'(1);
               end
            end

            if (apply) begin
               // A write in the apply cycle is newer than the shadow.
               if (wr) begin
                  limit <= cfg_limit;
                  os    <= cfg_oneshot;
               end else if (pend) begin
                  limit <= sh_limit;
                  os    <= sh_os;
               end
               pend <= 1'b0;
            end else if (wr) begin
               pend <= 1'b1;
            end

            if (wr) begin
               sh_limit <= cfg_limit;
               sh_os    <= cfg_oneshot;
            end
         end
      end
   end

endmodule

// File: tb/tb_mod_m_counter_bank.sv
// tb_mod_m_counter_bank: directed scoreboard bench for mod_m_counter_bank.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_mod_m_counter_bank;

   localparam int N  = 4;
   localparam int C  = 3;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [C-1:0]   en;
   logic [C-1:0]   clr;
   logic           cfg_we;
   logic [CW-1:0]  cfg_ch;
   logic [N-1:0]   cfg_limit;
   logic           cfg_oneshot;
   logic [C*N-1:0] q;
   logic [C-1:0]   tick;
   logic [C-1:0]   done;

   typedef struct {
      string          nm;
      logic [C*N-1:0] q;
      logic [C-1:0]   t;
      logic [C-1:0]   d;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mod_m_counter_bank #(.N(N), .C(C), .M_DEFAULT(10)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .clr         (clr),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_limit   (cfg_limit),
      .cfg_oneshot (cfg_oneshot),
      .q           (q),
      .tick        (tick),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are stable mid-cycle, compare every queued entry.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (q !== e.q || tick !== e.t || done !== e.d) begin
            n_bad++;
            $display("FAIL %s: got q=%h tick=%b done=%b, want q=%h tick=%b done=%b",
                     e.nm, q, tick, done, e.q, e.t, e.d);
         end
      end
   end

   task automatic expect_out(input string nm, input logic [N-1:0] q0,
                             input logic [N-1:0] q1, input logic [C-1:0] t,
                             input logic [C-1:0] d);
      exp_t e;
      e.nm = nm;
      e.q  = {4'd0, q1, q0};
      e.t  = t;
      e.d  = d;
      sb.push_back(e);
   endtask

   // One cycle: drive inputs, queue outputs expected before the edge.
   task automatic st(input string nm, input logic [C-1:0] e, input logic [C-1:0] c,
                     input logic we, input logic [CW-1:0] ch,
                     input logic [N-1:0] lim, input logic os,
                     input logic [N-1:0] q0, input logic [N-1:0] q1,
                     input logic [C-1:0] t, input logic [C-1:0] d);
      en          = e;
      clr         = c;
      cfg_we      = we;
      cfg_ch      = ch;
      cfg_limit   = lim;
      cfg_oneshot = os;
      expect_out(nm, q0, q1, t, d);
      @(posedge clk);
      #1;
   endtask

   task automatic cnt(input string nm, input logic [C-1:0] e,
                      input logic [N-1:0] q0, input logic [N-1:0] q1,
                      input logic [C-1:0] t, input logic [C-1:0] d);
      st(nm, e, 3'b000, 1'b0, 2'd0, 4'd0, 1'b0, q0, q1, t, d);
   endtask

   initial begin
      reset_n     = 1'b0;
      en          = '0;
      clr         = '0;
      cfg_we      = 1'b0;
      cfg_ch      = '0;
      cfg_limit   = '0;
      cfg_oneshot = 1'b0;
      @(posedge clk);
      #1;
      expect_out("in_reset", 4'd0, 4'd0, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Default modulus 10 on ch0, ch1 idle.
      for (int k = 0; k < 12; k++)
         cnt("dflt", 3'b001, 4'(k % 10), 4'd0,
             (k % 10 == 9) ? 3'b001 : 3'b000, 3'b000);

      // Stage limit 3 at q0=5; old period finishes first.
      for (int k = 2; k <= 4; k++)
         cnt("pre_wr", 3'b001, 4'(k), 4'd0, 3'b000, 3'b000);
      st("wr_lim3", 3'b001, 3'b000, 1'b1, 2'd0, 4'd3, 1'b0,
         4'd5, 4'd0, 3'b000, 3'b000);
      for (int k = 6; k <= 8; k++)
         cnt("finish_old", 3'b001, 4'(k), 4'd0, 3'b000, 3'b000);
      cnt("tick9", 3'b001, 4'd9, 4'd0, 3'b001, 3'b000);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k <= 3; k++)
            cnt("lim3", 3'b001, 4'(k), 4'd0,
                (k == 3) ? 3'b001 : 3'b000, 3'b000);

      // One-shot on ch1 with limit 2, applied by clr.
      st("wr_ch1", 3'b000, 3'b000, 1'b1, 2'd1, 4'd2, 1'b1,
         4'd0, 4'd0, 3'b000, 3'b000);
      st("clr1", 3'b000, 3'b010, 1'b0, 2'd0, 4'd0, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b000);
      cnt("os_0", 3'b010, 4'd0, 4'd0, 3'b000, 3'b000);
      cnt("os_1", 3'b010, 4'd0, 4'd1, 3'b000, 3'b000);
      cnt("os_tick", 3'b010, 4'd0, 4'd2, 3'b010, 3'b000);
      cnt("os_done", 3'b010, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("os_frozen", 3'b010, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("os_frozen2", 3'b010, 4'd0, 4'd0, 3'b000, 3'b010);
      st("clr_done", 3'b010, 3'b010, 1'b0, 2'd0, 4'd0, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      cnt("os2_0", 3'b010, 4'd0, 4'd0, 3'b000, 3'b000);
      cnt("os2_1", 3'b010, 4'd0, 4'd1, 3'b000, 3'b000);
      cnt("os2_tick", 3'b010, 4'd0, 4'd2, 3'b010, 3'b000);
      cnt("os2_done", 3'b000, 4'd0, 4'd0, 3'b000, 3'b010);

      // Write in the wrap cycle bypasses straight to the limit.
      cnt("bp_0", 3'b001, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("bp_1", 3'b001, 4'd1, 4'd0, 3'b000, 3'b010);
      cnt("bp_2", 3'b001, 4'd2, 4'd0, 3'b000, 3'b010);
      st("wrap_wr", 3'b001, 3'b000, 1'b1, 2'd0, 4'd1, 1'b0,
         4'd3, 4'd0, 3'b001, 3'b010);
      cnt("lim1_0", 3'b001, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("lim1_1", 3'b001, 4'd1, 4'd0, 3'b001, 3'b010);
      cnt("lim1_0b", 3'b001, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("lim1_1b", 3'b001, 4'd1, 4'd0, 3'b001, 3'b010);
      st("stage2", 3'b001, 3'b000, 1'b1, 2'd0, 4'd2, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      cnt("staged_not_applied", 3'b001, 4'd1, 4'd0, 3'b001, 3'b010);
      cnt("lim2_0", 3'b001, 4'd0, 4'd0, 3'b000, 3'b010);
      cnt("lim2_1", 3'b001, 4'd1, 4'd0, 3'b000, 3'b010);
      cnt("lim2_2", 3'b001, 4'd2, 4'd0, 3'b001, 3'b010);

      // Limit 0: tick every enabled cycle; out-of-range write ignored.
      st("wr_lim0", 3'b000, 3'b000, 1'b1, 2'd0, 4'd0, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      st("clr0_mask", 3'b001, 3'b001, 1'b0, 2'd0, 4'd0, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      for (int k = 0; k < 3; k++)
         cnt("lim0", 3'b001, 4'd0, 4'd0, 3'b001, 3'b010);
      st("oor_wr", 3'b001, 3'b000, 1'b1, 2'd3, 4'd5, 1'b1,
         4'd0, 4'd0, 3'b001, 3'b010);
      for (int k = 0; k < 2; k++)
         cnt("after_oor", 3'b001, 4'd0, 4'd0, 3'b001, 3'b010);

      // Limit 9 via clr+write bypass; stage a ch1 write to be lost.
      st("clr_lim9", 3'b000, 3'b001, 1'b1, 2'd0, 4'd9, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      st("stage_ch1", 3'b000, 3'b000, 1'b1, 2'd1, 4'd1, 1'b0,
         4'd0, 4'd0, 3'b000, 3'b010);
      for (int k = 0; k <= 6; k++)
         cnt("to7", 3'b001, 4'(k), 4'd0, 3'b000, 3'b010);

      // q0 is now 7 and done[1]=1; reset must act before the next edge.
      reset_n = 1'b0;
      expect_out("async_rst", 4'd0, 4'd0, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      en      = '0;
      reset_n = 1'b1;

      // Defaults restored on both channels; staged ch1 limit gone.
      for (int k = 0; k < 13; k++)
         cnt("post_rst", 3'b011, 4'(k % 10), 4'(k % 10),
             (k % 10 == 9) ? 3'b011 : 3'b000, 3'b000);

      en = '0;
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, want finish");
      $fatal(1, "timeout");
   end

endmodule
